x1_cmd_arbiter: RTL

- Shares the single Neuromorphic_X1 core command port between two requesters: req0 = Wishbone host path, req1 = autonomous scan/refresh engine.
- Commands use the X1 32-bit command word {mode[31:30], row[29:25], col[24:20], data[19:0]}.
  - mode 2'b11 = program; mode 2'b01 = read.
- The block grants requesters round-robin, registers the winning command toward the core, and tracks outstanding reads so each in-order core response returns to the requester that issued it.

---
 rtl/x1_cmd_arbiter_pkg.sv | 37 +++
 rtl/x1_cmd_arbiter_if.sv | 44 ++++
 rtl/x1_cmd_arbiter_tag_fifo.sv | 57 +++++
 rtl/x1_cmd_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/x1_cmd_arbiter_pkg.sv
// Shared X1 command-word definitions for the command arbiter slice.
// Mode encodings, field offsets, command/requester typedefs and a mode classifier.
package x1_pkg;

  localparam logic [1:0] X1_MODE_PROG = 2'b11;
  localparam logic [1:0] X1_MODE_READ = 2'b01;

  localparam int MODE_MSB = 31;
  localparam int ROW_LSB  = 25;
  localparam int COL_LSB  = 20;

  typedef struct packed {
    logic [1:0]  mode;
    logic [4:0]  row;
    logic [4:0]  col;
    logic [19:0] data;
  } x1_cmd_t;

  typedef logic req_id_t;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_FWD_READ,
    ACT_FWD_PROG,
    ACT_DROP
  } x1_action_e;

  // Reserved modes (2'b00, 2'b10) are swallowed rather than forwarded to the core.
  function automatic x1_action_e classify(input logic [1:0] mode);
    case (mode)
      X1_MODE_READ: return ACT_FWD_READ;
      X1_MODE_PROG: return ACT_FWD_PROG;
      default:      return ACT_DROP;
    endcase
  endfunction

endpackage

// File: rtl/x1_cmd_arbiter_if.sv
// Bundle of requester, core and status signals around the X1 command arbiter.
// The slave modport is the arbiter; the master modport is its surroundings.
interface x1_cmd_arbiter_if #(
  parameter int CMD_W     = 32,
  parameter int OUT_DEPTH = 8
);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  logic             req0_valid;
  logic             req0_ready;
  logic [CMD_W-1:0] req0_cmd;
  logic             req1_valid;
  logic             req1_ready;
  logic [CMD_W-1:0] req1_cmd;
  logic             core_cmd_valid;
  logic             core_cmd_ready;
  logic [CMD_W-1:0] core_cmd;
  logic             core_rsp_valid;
  logic [CMD_W-1:0] core_rsp_data;
  logic             rsp0_valid;
  logic [CMD_W-1:0] rsp0_data;
  logic             rsp1_valid;
  logic [CMD_W-1:0] rsp1_data;
  logic [CNT_W-1:0] rd_outstanding;
  logic             err_reserved;
  logic             err_orphan;

  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd,
    output core_cmd_ready, core_rsp_valid, core_rsp_data,
    input  req0_ready, req1_ready, core_cmd_valid, core_cmd,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  rd_outstanding, err_reserved, err_orphan
  );

  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd,
    input  core_cmd_ready, core_rsp_valid, core_rsp_data,
    output req0_ready, req1_ready, core_cmd_valid, core_cmd,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output rd_outstanding, err_reserved, err_orphan
  );

endinterface

// File: rtl/x1_cmd_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per outstanding core read.
// Pushes while full and pops while empty are ignored.
module x1_tag_fifo
  import x1_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  req_id_t                i_id,
  output req_id_t                o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_id_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_id;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/x1_cmd_arbiter.sv
// Round-robin arbiter sharing the X1 core command port between two requesters.
// Optional macro X1_ARB_STATS_EN adds saturating grant/stall counters.
module x1_cmd_arbiter
  import x1_pkg::*;
#(
  parameter int OUT_DEPTH = 8,
  parameter int CMD_W     = 32
) (
  input  logic        user_clk,
  input  logic        user_rst,
`ifdef X1_ARB_STATS_EN
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
  output logic [15:0] stall_cnt,
`endif
  x1_cmd_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  logic             r_slot_full;
  logic [CMD_W-1:0] r_slot_cmd;
  req_id_t          r_last_grant;
  logic             r_err_reserved;
  logic             r_err_orphan;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [CMD_W-1:0] r_rsp0_data;
  logic [CMD_W-1:0] r_rsp1_data;

  x1_action_e       w_act0;
  x1_action_e       w_act1;
  x1_action_e       w_acc_act;
  logic             w_can_accept;
  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [CMD_W-1:0] w_acc_cmd;
  logic             w_drain;
  logic             w_push;
  logic             w_pop_ok;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  req_id_t          w_head;
  logic [CNT_W-1:0] w_count;

  assign w_act0 = classify(bus.req0_cmd[MODE_MSB -: 2]);
  assign w_act1 = classify(bus.req1_cmd[MODE_MSB -: 2]);

  // Reset gates acceptance so no requester sees ready while the block is held.
  always_comb begin
    w_can_accept = !user_rst && (!r_slot_full || bus.core_cmd_ready);
    w_elig0   = bus.req0_valid && w_can_accept && (w_act0 != ACT_FWD_READ || !w_fifo_full);
    w_elig1   = bus.req1_valid && w_can_accept && (w_act1 != ACT_FWD_READ || !w_fifo_full);
    w_grant0  = w_elig0 && (!w_elig1 || r_last_grant == 1'b1);
    w_grant1  = w_elig1 && (!w_elig0 || r_last_grant == 1'b0);
    w_accept  = w_grant0 || w_grant1;
    w_acc_cmd = w_grant1 ? bus.req1_cmd : bus.req0_cmd;
    w_acc_act = ACT_NONE;
    if (w_accept) w_acc_act = w_grant1 ? w_act1 : w_act0;
  end

  assign w_drain  = r_slot_full && bus.core_cmd_ready;
  assign w_push   = (w_acc_act == ACT_FWD_READ);
  assign w_pop_ok = bus.core_rsp_valid && !w_fifo_empty;

  x1_tag_fifo #(.DEPTH(OUT_DEPTH)) u_tag_fifo (
    .clk     (user_clk),
    .rst     (user_rst),
    .i_push  (w_push),
    .i_pop   (bus.core_rsp_valid),
    .i_id    (w_grant1),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_slot_full    <= 1'b0;
      r_slot_cmd     <= '0;
      r_last_grant   <= 1'b1;
      r_err_reserved <= 1'b0;
      r_err_orphan   <= 1'b0;
    end else begin
      if (w_accept) r_last_grant <= w_grant1;
      if (w_acc_act == ACT_FWD_READ || w_acc_act == ACT_FWD_PROG) begin
        r_slot_full <= 1'b1;
        r_slot_cmd  <= w_acc_cmd;
      end else if (w_drain) begin
        r_slot_full <= 1'b0;
      end
      if (w_acc_act == ACT_DROP) r_err_reserved <= 1'b1;
      if (bus.core_rsp_valid && w_fifo_empty) r_err_orphan <= 1'b1;
    end
  end

  // Responses return in issue order, so the FIFO head names the owner.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
    end else begin
      r_rsp0_valid <= w_pop_ok && (w_head == 1'b0);
      r_rsp1_valid <= w_pop_ok && (w_head == 1'b1);
      if (w_pop_ok && w_head == 1'b0) r_rsp0_data <= bus.core_rsp_data;
      if (w_pop_ok && w_head == 1'b1) r_rsp1_data <= bus.core_rsp_data;
    end
  end

  assign bus.req0_ready     = w_grant0;
  assign bus.req1_ready     = w_grant1;
  assign bus.core_cmd_valid = r_slot_full;
  assign bus.core_cmd       = r_slot_cmd;
  assign bus.rsp0_valid     = r_rsp0_valid;
  assign bus.rsp0_data      = r_rsp0_data;
  assign bus.rsp1_valid     = r_rsp1_valid;
  assign bus.rsp1_data      = r_rsp1_data;
  assign bus.rd_outstanding = w_count;
  assign bus.err_reserved   = r_err_reserved;
  assign bus.err_orphan     = r_err_orphan;

`ifdef X1_ARB_STATS_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_grant0 && r_grant_cnt0 != 16'hFFFF) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (w_grant1 && r_grant_cnt1 != 16'hFFFF) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
      if ((bus.req0_valid || bus.req1_valid) && !w_accept && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule
